roi_pool_capture: RTL and testbench
===================================

Name: roi_pool_capture

Overview:
- Parametrised successor to the fixed-centre 28x28 ROI averager.
- Pools a runtime-positioned ROI of size (ROI_W*REC_W) x (ROI_H*REC_H) from the active video stream into an ROI_W x ROI_H u8 buffer.
- Pooling mode is selectable: average, max, min or subsample, with optional inversion.
- Capture is armed by a handshake, so the CNN input RAM is written exactly once per request. The block sits between vga_timing/framebuffer readout and the CNN input RAM.

Parameters:
- H_ACTIVE, 640, active line width in pixels
- V_ACTIVE, 480, active line count
- ROI_W, 28, output columns
- ROI_H, 28, output rows
- REC_LOG2_W, 3, log2 of block width (REC_W = 1<<REC_LOG2_W)
- REC_LOG2_H, 3, log2 of block height
- ADDR_W, 10, roi_addr width; must satisfy 2^ADDR_W >= ROI_W*ROI_H
- CONTINUOUS, 0, 1 = re-arm automatically after each completed frame

Ports:
- pclk, input, 1, pixel clock
- rst, input, 1, asynchronous active-high reset
- x, input, 10, active column
- y, input, 10, active row
- de, input, 1, active-video valid
- pix_u8, input, 8, grayscale pixel
- cfg_mode, input, 2, 0=avg, 1=max, 2=min, 3=subsample (top-left of block)
- cfg_invert, input, 1, output 255-result
- cfg_box_x0, input, 10, requested ROI left edge
- cfg_box_y0, input, 10, requested ROI top edge
- cap_arm, input, 1, one-cycle capture request
- cap_busy, output, 1, high from accepted arm until frame done
- roi_we, output, 1, write strobe
- roi_addr, output, ADDR_W, row-major address
- roi_dout, output, 8, pooled pixel
- roi_frame_done, output, 1, one-cycle pulse coincident with the last roi_we
- box_left, output, 10, latched ROI left edge
- box_right, output, 10, latched ROI right edge (exclusive)
- box_up, output, 10, latched ROI top edge
- box_down, output, 10, latched ROI bottom edge (exclusive)

Behaviour:
- Reset (async, rst=1):
  - State IDLE (WAIT_SOF if CONTINUOUS=1).
  - All outputs 0; the box registers hold the centred default (LEFT=(H_ACTIVE-BOX_W)/2, UP likewise).
  - Accumulators cleared.
- SOF = de && x==0 && y==0.
- State machine:
  - IDLE: cap_arm=1 -> WAIT_SOF; cap_busy=1 from the next cycle.
  - WAIT_SOF: on SOF, latch cfg_mode, cfg_invert and the clamped box origin, then go to CAPTURE. The SOF pixel is processed normally; it lies in the box only if the origin is 0,0.
  - CAPTURE: pool pixels. When the block at (ROI_W-1, ROI_H-1) completes, go to DONE.
  - DONE (one cycle): roi_frame_done and the final roi_we are already issued. Then go to IDLE with cap_busy=0, or to WAIT_SOF if CONTINUOUS=1.
- cap_arm is ignored outside IDLE.
- A SOF seen during CAPTURE (frame truncated, e.g. de stalls) aborts the capture and restarts it on that SOF with freshly latched config. No frame_done is issued for the aborted frame.
- Clamp: x0 = min(cfg_box_x0, H_ACTIVE-BOX_W), y0 = min(cfg_box_y0, V_ACTIVE-BOX_H). box_* reflect the latched, clamped values.
- in_box = de && x in [x0, x0+BOX_W) && y in [y0, y0+BOX_H).
- Indexing: xr=x-x0 and yr=y-y0. The block index is xr >> REC_LOG2_W; the sub-offset is the low bits. No dividers.
- Accumulator per column: width 8+REC_LOG2_W+REC_LOG2_H.
  - At sub_x==0 && sub_y==0, load the pixel (avg: sum=pix; max/min: reg=pix; subsample: hold=pix).
  - Otherwise: avg adds; max keeps the larger value; min keeps the smaller; subsample holds.
- At the last sub-pixel of a block, the result is registered on the next edge (roi_we one cycle after that pixel):
  - avg result = (sum_incl_current + N/2) >> (REC_LOG2_W+REC_LOG2_H).
  - max/min include the current pixel.
  - Invert is applied after pooling.
  - roi_addr = by*ROI_W + bx.
- roi_we is never asserted outside CAPTURE. Writes are strictly in row-major order, exactly ROI_W*ROI_H per completed frame.
- de low inside box coordinates contributes nothing; accumulators keep their values.
- Reset mid-capture: immediate return to the reset state. No further roi_we. Partial RAM contents are undefined to the consumer, which gates on roi_frame_done.

Decomposition:
- Package roi_pool_pkg:
  - Mode encodings: MODE_AVG, MODE_MAX, MODE_MIN, MODE_SUB.
  - State encodings: IDLE, WAIT_SOF, CAPTURE, DONE.
  - Helper functions for BOX_W/BOX_H/ACC_W.
- Sub-module pool_lane: one column accumulator with mode-select combine and finalise logic. It is instantiated ROI_W times (or a shared lane with a column-indexed register file).
- Top level: FSM, config latch/clamp, indexing.

Test Plan:
- Flat frame pix=100, mode avg, arm, origin (208,128) -> 784 writes, addr 0..783 in order, all dout=100, frame_done on write 784, cap_busy falls next cycle.
- Block (0,0) pixels 0..63 ramp, avg -> dout=32 ((2016+32)>>6). Same block, max -> 63; min -> 0; sub -> 0; avg with invert -> 223.
- cfg_box_x0=600, cfg_box_y0=400 -> box_left=416, box_up=256, box_right=640, box_down=480; 784 writes.
- Arm in IDLE with no SOF for 1000 cycles -> no writes, cap_busy=1. A second arm while busy is ignored, giving exactly one capture.
- rst asserted after write 300 -> outputs 0 within the same cycle (async), no writes after release until the next arm+SOF.
- CONTINUOUS=1 over 3 frames -> 3 frame_done pulses, 2352 writes. A SOF injected mid-frame -> that frame aborted, no frame_done, capture restarts.

Source files
------------

// File: rtl/roi_pool_pkg.sv
// roi_pool_capture shared types
// pooling modes, capture states, sizing helpers
package roi_pool_pkg;

  typedef enum logic [1:0] {
    MODE_AVG = 2'd0,
    MODE_MAX = 2'd1,
    MODE_MIN = 2'd2,
    MODE_SUB = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    CAPTURE,
    DONE
  } state_e;

  function automatic int box_dim(
    input int blocks,
    input int rec_log2
  );
    return blocks << rec_log2;
  endfunction

  function automatic int acc_width(
    input int lw,
    input int lh
  );
    return 8 + lw + lh;
  endfunction

endpackage

// File: rtl/roi_pool_capture_lane.sv
// pool_lane: one ROI column accumulator
// combine per mode, finalise incl. current pixel
module pool_lane
  import roi_pool_pkg::*;
#(
  parameter int ACC_W = 14,
  parameter int SHIFT = 6
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       en,
  input  logic       first,
  input  mode_e      mode,
  input  logic [7:0] pix,
  output logic [7:0] res
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] nxt;
  logic [ACC_W-1:0] pix_w;
  logic [ACC_W-1:0] rnd;

  assign pix_w = ACC_W'(pix);

  always_comb begin
    nxt = acc;
    unique case (mode)
      MODE_AVG: nxt = acc + pix_w;
      MODE_MAX: nxt = (pix_w > acc) ? pix_w : acc;
      MODE_MIN: nxt = (pix_w < acc) ? pix_w : acc;
      MODE_SUB: nxt = acc;
    endcase
    if (first) nxt = pix_w;
  end

  // round-to-nearest: add N/2 before the shift
  assign rnd = nxt + ((ACC_W'(1) << SHIFT) >> 1);

  always_comb begin
    res = nxt[7:0];
    if (mode == MODE_AVG) res = 8'(rnd >> SHIFT);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) acc <= '0;
    else if (en) acc <= nxt;
  end

endmodule

// File: rtl/roi_pool_capture.sv
// roi_pool_capture: armed one-shot ROI pooling
// FSM, config latch/clamp, block indexing, write port
module roi_pool_capture
  import roi_pool_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ROI_W      = 28,
  parameter int ROI_H      = 28,
  parameter int REC_LOG2_W = 3,
  parameter int REC_LOG2_H = 3,
  parameter int ADDR_W     = 10,
  parameter int CONTINUOUS = 0
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              de,
  input  logic [7:0]        pix_u8,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_invert,
  input  logic [9:0]        cfg_box_x0,
  input  logic [9:0]        cfg_box_y0,
  input  logic              cap_arm,
  output logic              cap_busy,
  output logic              roi_we,
  output logic [ADDR_W-1:0] roi_addr,
  output logic [7:0]        roi_dout,
  output logic              roi_frame_done,
  output logic [9:0]        box_left,
  output logic [9:0]        box_right,
  output logic [9:0]        box_up,
  output logic [9:0]        box_down
);

  localparam int BOX_W = box_dim(ROI_W, REC_LOG2_W);
  localparam int BOX_H = box_dim(ROI_H, REC_LOG2_H);
  localparam int ACC_W = acc_width(REC_LOG2_W, REC_LOG2_H);
  localparam int BXW   = 10 - REC_LOG2_W;
  localparam int BYW   = 10 - REC_LOG2_H;
  localparam logic [9:0] X_MAX = 10'(H_ACTIVE - BOX_W);
  localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - BOX_H);
  localparam logic [9:0] X_DEF = 10'((H_ACTIVE - BOX_W) / 2);
  localparam logic [9:0] Y_DEF = 10'((V_ACTIVE - BOX_H) / 2);
  localparam state_e RST_ST =
    (CONTINUOUS != 0) ? WAIT_SOF : IDLE;

  state_e state, state_n;
  mode_e  mode_q, mode_c;
  logic   inv_q, inv_c;
  logic [9:0] x0_c, y0_c;
  logic [9:0] xr, yr;
  logic sof, latch, proc;
  logic in_box, active;
  logic first, last, frame_last;
  logic [BXW-1:0] bx;
  logic [BYW-1:0] by;
  logic [ROI_W-1:0] lane_sel;
  logic [7:0] lane_res [ROI_W];
  logic [7:0] res;

  assign sof   = de && (x == 10'd0) && (y == 10'd0);
  assign latch = sof &&
    ((state == WAIT_SOF) || (state == CAPTURE));
  assign proc  = latch || (state == CAPTURE);

  // the SOF pixel already sees the freshly latched config
  assign x0_c = !latch ? box_left :
    (cfg_box_x0 > X_MAX) ? X_MAX : cfg_box_x0;
  assign y0_c = !latch ? box_up :
    (cfg_box_y0 > Y_MAX) ? Y_MAX : cfg_box_y0;
  assign mode_c = latch ? mode_e'(cfg_mode) : mode_q;
  assign inv_c  = latch ? cfg_invert : inv_q;

  assign in_box = de &&
    (x >= x0_c) &&
    ({1'b0, x} < {1'b0, x0_c} + 11'(BOX_W)) &&
    (y >= y0_c) &&
    ({1'b0, y} < {1'b0, y0_c} + 11'(BOX_H));
  assign active = proc && in_box;

  assign xr = x - x0_c;
  assign yr = y - y0_c;
  assign bx = xr[9:REC_LOG2_W];
  assign by = yr[9:REC_LOG2_H];
  assign first = (xr[REC_LOG2_W-1:0] == '0) &&
                 (yr[REC_LOG2_H-1:0] == '0);
  assign last  = (&xr[REC_LOG2_W-1:0]) &&
                 (&yr[REC_LOG2_H-1:0]);
  assign frame_last = active && last &&
    (bx == BXW'(ROI_W - 1)) && (by == BYW'(ROI_H - 1));

  for (genvar i = 0; i < ROI_W; i++) begin : g_lane
    assign lane_sel[i] = (bx == BXW'(i));
    pool_lane #(
      .ACC_W(ACC_W),
      .SHIFT(REC_LOG2_W + REC_LOG2_H)
    ) u_lane (
      .pclk (pclk),
      .rst  (rst),
      .en   (active && lane_sel[i]),
      .first(first),
      .mode (mode_c),
      .pix  (pix_u8),
      .res  (lane_res[i])
    );
  end

  always_comb begin
    res = '0;
    for (int i = 0; i < ROI_W; i++)
      if (lane_sel[i]) res = lane_res[i];
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (cap_arm) state_n = WAIT_SOF;
      WAIT_SOF, CAPTURE:
        if (frame_last) state_n = DONE;
        else if (latch) state_n = CAPTURE;
      DONE:
        state_n = (CONTINUOUS != 0) ? WAIT_SOF : IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state          <= RST_ST;
      cap_busy       <= 1'b0;
      mode_q         <= MODE_AVG;
      inv_q          <= 1'b0;
      box_left       <= X_DEF;
      box_up         <= Y_DEF;
      roi_we         <= 1'b0;
      roi_addr       <= '0;
      roi_dout       <= '0;
      roi_frame_done <= 1'b0;
    end else begin
      state          <= state_n;
      cap_busy       <= (state_n != IDLE);
      roi_we         <= active && last;
      roi_frame_done <= frame_last;
      if (latch) begin
        mode_q   <= mode_c;
        inv_q    <= inv_c;
        box_left <= x0_c;
        box_up   <= y0_c;
      end
      if (active && last) begin
        roi_addr <= ADDR_W'(by) * ADDR_W'(ROI_W) +
                    ADDR_W'(bx);
        roi_dout <= inv_c ? ~res : res;
      end
    end
  end

  assign box_right = box_left + 10'(BOX_W);
  assign box_down  = box_up + 10'(BOX_H);

endmodule

// File: tb/tb_roi_pool_capture.sv
// tb_roi_pool_capture: scoreboard bench
// one-shot and continuous instances share stimulus
module tb_roi_pool_capture;

  localparam int H  = 64;
  localparam int V  = 40;
  localparam int NW = 4;
  localparam int NH = 3;
  localparam int LW = 3;
  localparam int LH = 3;
  localparam int RW = 8;
  localparam int RH = 8;
  localparam int BW = NW * RW;
  localparam int BH = NH * RH;
  localparam int AW = 4;
  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_CAP  = 2;
  localparam int P_DONE = 3;

  typedef struct {
    int addr;
    int dout;
    int done;
  } wr_t;

  logic pclk, rst, de, cap_arm, cfg_invert;
  logic [9:0] x, y, cfg_x0, cfg_y0;
  logic [7:0] pix;
  logic [1:0] cfg_mode;
  logic [1:0] o_we, o_done, o_busy;
  logic [1:0][AW-1:0] o_addr;
  logic [1:0][7:0] o_dout;
  logic [1:0][9:0] o_bl, o_br, o_bu, o_bd;

  int tests = 0;
  int fails = 0;
  int wr_cnt [2];
  int done_cnt [2];
  int last_addr0 = -1;
  int first_d0 = -1;

  int ph [2];
  int m_x0 [2];
  int m_y0 [2];
  int m_mode [2];
  int m_inv [2];
  bit m_busy [2];
  logic [7:0] mem [2][BH][BW];
  bit vld [2][BH][BW];
  wr_t q0 [$];
  wr_t q1 [$];
  wr_t w;
  bit have;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    roi_pool_capture #(
      .H_ACTIVE(H), .V_ACTIVE(V),
      .ROI_W(NW), .ROI_H(NH),
      .REC_LOG2_W(LW), .REC_LOG2_H(LH),
      .ADDR_W(AW), .CONTINUOUS(g)
    ) u_dut (
      .pclk(pclk), .rst(rst),
      .x(x), .y(y), .de(de), .pix_u8(pix),
      .cfg_mode(cfg_mode),
      .cfg_invert(cfg_invert),
      .cfg_box_x0(cfg_x0),
      .cfg_box_y0(cfg_y0),
      .cap_arm(cap_arm),
      .cap_busy(o_busy[g]),
      .roi_we(o_we[g]),
      .roi_addr(o_addr[g]),
      .roi_dout(o_dout[g]),
      .roi_frame_done(o_done[g]),
      .box_left(o_bl[g]),
      .box_right(o_br[g]),
      .box_up(o_bu[g]),
      .box_down(o_bd[g])
    );
  end

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string name, input int d,
                       input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0d, want %0d",
               name, d, act, exp);
    end
  endtask

  task automatic model_step(input int d);
    int xr, yr, bx, by, r, sum, mx, mn, v;
    bit sof;
    wr_t e;
    sof = de && (x == 0) && (y == 0);
    if (ph[d] == P_DONE) begin
      ph[d] = (d == 1) ? P_WAIT : P_IDLE;
    end else if (ph[d] == P_IDLE) begin
      if (cap_arm) ph[d] = P_WAIT;
    end else begin
      if (sof) begin
        m_x0[d] = (int'(cfg_x0) > H - BW) ? H - BW : int'(cfg_x0);
        m_y0[d] = (int'(cfg_y0) > V - BH) ? V - BH : int'(cfg_y0);
        m_mode[d] = int'(cfg_mode);
        m_inv[d] = int'(cfg_invert);
        ph[d] = P_CAP;
      end
      xr = int'(x) - m_x0[d];
      yr = int'(y) - m_y0[d];
      if (ph[d] == P_CAP && de && xr >= 0 && xr < BW &&
          yr >= 0 && yr < BH) begin
        if (xr % RW == 0 && yr % RH == 0)
          for (int i = 0; i < RH; i++)
            for (int j = 0; j < RW; j++)
              vld[d][yr+i][xr+j] = 1'b0;
        mem[d][yr][xr] = pix;
        vld[d][yr][xr] = 1'b1;
        if (xr % RW == RW - 1 && yr % RH == RH - 1) begin
          bx = xr / RW;
          by = yr / RH;
          sum = 0; mx = 0; mn = 255;
          for (int i = 0; i < RH; i++)
            for (int j = 0; j < RW; j++)
              if (vld[d][by*RH+i][bx*RW+j]) begin
                v = int'(mem[d][by*RH+i][bx*RW+j]);
                sum += v;
                if (v > mx) mx = v;
                if (v < mn) mn = v;
              end
          case (m_mode[d])
            0: r = (sum + RW * RH / 2) / (RW * RH);
            1: r = mx;
            2: r = mn;
            default: r = int'(mem[d][by*RH][bx*RW]);
          endcase
          if (m_inv[d] != 0) r = 255 - r;
          e.addr = by * NW + bx;
          e.dout = r;
          e.done = (bx == NW - 1 && by == NH - 1) ? 1 : 0;
          if (d == 0) q0.push_back(e);
          else q1.push_back(e);
          if (e.done != 0) ph[d] = P_DONE;
        end
      end
    end
    m_busy[d] = (ph[d] != P_IDLE);
  endtask

  always @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        ph[d] = (d == 1) ? P_WAIT : P_IDLE;
        m_x0[d] = (H - BW) / 2;
        m_y0[d] = (V - BH) / 2;
        m_busy[d] = 1'b0;
      end
      q0.delete();
      q1.delete();
    end else begin
      for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  always @(negedge pclk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        check("we", d, int'(o_we[d]), int'(have));
        if (have) begin
          if (d == 0) w = q0.pop_front();
          else w = q1.pop_front();
          if (o_we[d]) begin
            check("addr", d, int'(o_addr[d]), w.addr);
            check("dout", d, int'(o_dout[d]), w.dout);
            check("done", d, int'(o_done[d]), w.done);
          end
        end else begin
          check("done_idle", d, int'(o_done[d]), 0);
        end
        check("box_left", d, int'(o_bl[d]), m_x0[d]);
        check("box_right", d, int'(o_br[d]), m_x0[d] + BW);
        check("box_up", d, int'(o_bu[d]), m_y0[d]);
        check("box_down", d, int'(o_bd[d]), m_y0[d] + BH);
        if (d == 0)
          check("busy", d, int'(o_busy[0]), int'(m_busy[0]));
        if (o_we[d]) wr_cnt[d]++;
        if (o_done[d]) done_cnt[d]++;
      end
      if (o_we[0]) begin
        last_addr0 = int'(o_addr[0]);
        if (o_addr[0] == '0) first_d0 = int'(o_dout[0]);
      end
    end
  end

  function automatic logic [7:0] pixval(
    input int pat, input int off, input int xx, input int yy);
    case (pat)
      0: return 8'(off);
      1: return 8'((yy % 8) * 8 + (xx % 8) + off);
      default: return 8'(xx * 7 + yy * 13 + off);
    endcase
  endfunction

  task automatic run_frame(input int pat, input int off,
                           input int npix);
    for (int i = 0; i < npix; i++) begin
      @(negedge pclk);
      x = 10'(i % H);
      y = 10'(i / H);
      de = 1'b1;
      pix = pixval(pat, off, i % H, i / H);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      de = 1'b0;
    end
  endtask

  task automatic arm();
    @(negedge pclk);
    de = 1'b0;
    cap_arm = 1'b1;
    @(negedge pclk);
    cap_arm = 1'b0;
  endtask

  task automatic set_cfg(input int m, input int inv,
                         input int bx0, input int by0);
    cfg_mode = 2'(m);
    cfg_invert = (inv != 0);
    cfg_x0 = 10'(bx0);
    cfg_y0 = 10'(by0);
  endtask

  int ramp_tab [7][6] = '{
    '{0, 0, 16, 8, 0, 32},
    '{1, 0, 16, 8, 0, 63},
    '{2, 0, 16, 8, 0, 0},
    '{3, 0, 16, 8, 0, 0},
    '{0, 1, 16, 8, 0, 223},
    '{3, 0, 0, 0, 5, 5},
    '{1, 1, 0, 0, 5, 187}
  };
  int w0, d0, w1, d1;

  initial begin
    rst = 1'b1; de = 1'b0; x = '0; y = '0; pix = '0;
    cap_arm = 1'b0;
    wr_cnt = '{0, 0};
    done_cnt = '{0, 0};
    set_cfg(0, 0, 8, 8);
    repeat (3) @(negedge pclk);
    check("rst_we", 0, int'(o_we[0]), 0);
    check("rst_busy", 0, int'(o_busy[0]), 0);
    check("rst_done", 0, int'(o_done[0]), 0);
    check("rst_left", 0, int'(o_bl[0]), 16);
    check("rst_up", 0, int'(o_bu[0]), 8);
    check("rst_right", 0, int'(o_br[0]), 48);
    check("rst_down", 0, int'(o_bd[0]), 32);
    check("rst_we", 1, int'(o_we[1]), 0);
    rst = 1'b0;
    idle(3);

    // flat frame, average
    set_cfg(0, 0, 8, 8);
    arm();
    idle(2);
    check("armed_busy", 0, int'(o_busy[0]), 1);
    w0 = wr_cnt[0]; d0 = done_cnt[0];
    run_frame(0, 100, H * V);
    idle(4);
    check("flat_writes", 0, wr_cnt[0] - w0, NW * NH);
    check("flat_done", 0, done_cnt[0] - d0, 1);
    check("flat_dout", 0, first_d0, 100);
    check("flat_last_addr", 0, last_addr0, NW * NH - 1);
    check("flat_busy_end", 0, int'(o_busy[0]), 0);

    // ramp block 0..63 under every mode
    for (int k = 0; k < 7; k++) begin
      set_cfg(ramp_tab[k][0], ramp_tab[k][1],
              ramp_tab[k][2], ramp_tab[k][3]);
      first_d0 = -1;
      arm();
      run_frame(1, ramp_tab[k][4], H * V);
      idle(4);
      check("ramp_dout", k, first_d0, ramp_tab[k][5]);
    end

    // clamp of an out-of-range origin
    set_cfg(0, 0, 600, 400);
    arm();
    w0 = wr_cnt[0];
    run_frame(2, 3, H * V);
    idle(4);
    check("clamp_left", 0, int'(o_bl[0]), 32);
    check("clamp_up", 0, int'(o_bu[0]), 16);
    check("clamp_right", 0, int'(o_br[0]), 64);
    check("clamp_down", 0, int'(o_bd[0]), 40);
    check("clamp_writes", 0, wr_cnt[0] - w0, NW * NH);

    // armed with no SOF, then a redundant arm
    set_cfg(1, 0, 8, 8);
    w0 = wr_cnt[0]; d0 = done_cnt[0];
    arm();
    idle(1000);
    check("nosof_writes", 0, wr_cnt[0] - w0, 0);
    check("nosof_busy", 0, int'(o_busy[0]), 1);
    arm();
    run_frame(2, 11, H * V);
    run_frame(2, 17, H * V);
    idle(4);
    check("once_writes", 0, wr_cnt[0] - w0, NW * NH);
    check("once_done", 0, done_cnt[0] - d0, 1);

    // reset in the middle of a capture
    set_cfg(1, 0, 8, 8);
    arm();
    w0 = wr_cnt[0];
    run_frame(2, 29, 1500);
    check("pre_rst_writes", 0, wr_cnt[0] - w0, 6);
    #2 rst = 1'b1;
    #1;
    check("arst_we", 0, int'(o_we[0]), 0);
    check("arst_busy", 0, int'(o_busy[0]), 0);
    check("arst_addr", 0, int'(o_addr[0]), 0);
    check("arst_dout", 0, int'(o_dout[0]), 0);
    check("arst_left", 0, int'(o_bl[0]), 16);
    idle(3);
    rst = 1'b0;
    w0 = wr_cnt[0];
    run_frame(2, 31, H * V);
    idle(4);
    check("post_rst_writes", 0, wr_cnt[0] - w0, 0);

    // continuous capture, three back-to-back frames
    set_cfg(2, 1, 24, 4);
    w1 = wr_cnt[1]; d1 = done_cnt[1];
    for (int k = 0; k < 3; k++) run_frame(2, 40 + k, H * V);
    idle(4);
    check("cont_done", 1, done_cnt[1] - d1, 3);
    check("cont_writes", 1, wr_cnt[1] - w1, 3 * NW * NH);

    // truncated frame restarted by an early SOF
    set_cfg(0, 1, 8, 8);
    arm();
    d0 = done_cnt[0]; d1 = done_cnt[1];
    run_frame(2, 50, 1500);
    run_frame(2, 60, H * V);
    idle(4);
    check("abort_done", 0, done_cnt[0] - d0, 1);
    check("abort_done", 1, done_cnt[1] - d1, 1);
    check("abort_last_addr", 0, last_addr0, NW * NH - 1);
    check("end_queue", 0, q0.size(), 0);
    check("end_queue", 1, q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
